freq_spec_display: RTL

Parametrised, frame-synchronous spectrum-analyser renderer for the 640x480 VGA path, driven from `clk50`. Band levels arrive through a write port into shadow registers. All shadow levels are copied into active registers once per frame at the start of vertical blanking, so bars never tear mid-frame. Each band also carries a peak-hold marker with hold time and linear decay, and bars are drawn as stacked segments in a per-band colour.

---
 rtl/freq_spec_display.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/freq_spec_display.sv
// Frame-synchronous spectrum-analyser bar renderer for 640x480 VGA on clk50.
// Band levels are double-buffered and latched at the start of vertical blanking; each band has a peak-hold marker.
module freq_spec_display #(
  parameter int unsigned NBANDS      = 12,
  parameter int unsigned LVL_W       = 9,
  parameter int unsigned BAR_W       = 48,
  parameter int unsigned GAP         = 4,
  parameter int unsigned X0          = 10,
  parameter int unsigned SEG         = 8,
  parameter int unsigned PEAK_H      = 2,
  parameter int unsigned HOLD_FRAMES = 30,
  parameter int unsigned DECAY       = 4
) (
  input  logic                      clk50,
  input  logic                      reset_n,
  input  logic                      band_we,
  input  logic [$clog2(NBANDS)-1:0] band_addr,
  input  logic [LVL_W-1:0]          band_level,
  output logic                      frame_tick,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B,
  output logic                      VGA_CLK,
  output logic                      VGA_HS,
  output logic                      VGA_VS,
  output logic                      VGA_BLANK_n,
  output logic                      VGA_SYNC_n
);

  localparam int unsigned AW      = $clog2(NBANDS);
  localparam int unsigned SW      = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int unsigned HW      = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam int unsigned CW      = (LVL_W > 10) ? LVL_W + 1 : 11;
  localparam int unsigned PITCH   = BAR_W + GAP;
  localparam int unsigned MAX_LVL = 480;
  localparam logic [23:0] BG_RGB  = 24'h202020;

  if (X0 + NBANDS * PITCH - GAP > 640) begin : g_bad_geometry
    $error("freq_spec_display: bars do not fit in 640 columns");
  end
  if (NBANDS < 2 || NBANDS > 16) begin : g_bad_nbands
    $error("freq_spec_display: NBANDS must be 2..16");
  end

  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic [SW-1:0] seg_row;
  logic          line_end;
  logic          latch;
  logic          active;
  logic          gap_row;
  logic [9:0]    col;
  logic [9:0]    row;
  logic [LVL_W-1:0] wr_level;
  logic [NBANDS-1:0] in_win;
  logic [23:0]   band_rgb [NBANDS];
  logic [23:0]   pix;

  assign line_end   = (hcount == 11'd1599);
  assign latch      = (vcount == 10'd480) && (hcount == 11'd0);
  assign frame_tick = latch;
  assign active     = (hcount < 11'd1280) && (vcount < 10'd480);
  assign gap_row    = (seg_row == SW'(SEG - 1));
  assign col        = hcount[10:1];
  assign row        = vcount;
  assign wr_level   = (CW'(band_level) > CW'(MAX_LVL)) ? LVL_W'(MAX_LVL) : band_level;
  assign VGA_SYNC_n = 1'b1;

  // Raster counters; seg_row tracks row modulo SEG and realigns at the top of each frame.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      hcount  <= '0;
      vcount  <= '0;
      seg_row <= '0;
    end else if (line_end) begin
      hcount  <= '0;
      vcount  <= (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
      seg_row <= (vcount == 10'd524 || seg_row == SW'(SEG - 1)) ? SW'(0) : seg_row + SW'(1);
    end else begin
      hcount  <= hcount + 11'd1;
    end
  end

  for (genvar i = 0; i < NBANDS; i++) begin : g_band
    localparam int unsigned LO = X0 + i * PITCH;
    localparam logic [7:0]  RI = 8'((i * 255) / (NBANDS - 1));

    logic [LVL_W-1:0] shadow, act, peak, sub, decayed;
    logic [HW-1:0]    hold;
    logic [CW-1:0]    peak_sum, act_sum;
    logic             peak_hit, bar_hit;

    assign sub     = (CW'(peak) > CW'(DECAY)) ? LVL_W'(CW'(peak) - CW'(DECAY)) : '0;
    assign decayed = (sub > shadow) ? sub : shadow;

    // A write in the latch cycle reaches the shadow only; act copies the old shadow value.
    always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
        shadow <= '0;
        act    <= '0;
        peak   <= '0;
        hold   <= '0;
      end else begin
        if (band_we && band_addr == AW'(i)) shadow <= wr_level;
        if (latch) begin
          act <= shadow;
          if (shadow >= peak) begin
            peak <= shadow;
            hold <= HW'(HOLD_FRAMES);
          end else if (hold != '0) begin
            hold <= hold - HW'(1);
          end else begin
            peak <= decayed;
          end
        end
      end
    end

    assign peak_sum  = CW'(row) + CW'(peak);
    assign act_sum   = CW'(row) + CW'(act);
    assign peak_hit  = (peak != '0) && (peak_sum >= CW'(MAX_LVL)) && (peak_sum < CW'(MAX_LVL + PEAK_H));
    assign bar_hit   = (act_sum >= CW'(MAX_LVL)) && !gap_row;
    assign in_win[i] = (col >= 10'(LO)) && (col < 10'(LO + BAR_W));
    assign band_rgb[i] = peak_hit ? 24'hFFFFFF : bar_hit ? {RI, 8'h30, 8'hFF - RI} : BG_RGB;
  end

  // Bar windows never overlap, so at most one band claims the column.
  always_comb begin
    pix = BG_RGB;
    for (int i = 0; i < NBANDS; i++) begin
      if (in_win[i]) pix = band_rgb[i];
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_n <= 1'b0;
      VGA_CLK     <= 1'b0;
    end else begin
      VGA_CLK     <= hcount[0];
      VGA_HS      <= !((hcount >= 11'd1312) && (hcount <= 11'd1503));
      VGA_VS      <= !((vcount >= 10'd490) && (vcount <= 10'd491));
      VGA_BLANK_n <= active;
      {VGA_R, VGA_G, VGA_B} <= active ? pix : 24'h000000;
    end
  end

endmodule
